// File: rtl/rom_loader.sv
// ============================================================================
// Module   : rom_loader
// Purpose  : Packs the HPS byte-download stream into DW-bit little-endian
//            words and writes them to the boot image RAM over ready/valid.
//            Optional running byte checksum: define ROM_LOADER_CSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_loader #(
  parameter int         DW   = 16,
  parameter int         AW   = 13,
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_wait,
  output logic          mem_we,
  input  logic          mem_rdy,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   csum
);

  localparam int c_NB  = DW / 8;
  localparam int c_LB  = $clog2(c_NB);
  localparam int c_LBW = (c_LB > 0) ? c_LB : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic            r_active_d;
  logic [c_NB-1:0] r_mask;
  logic [DW-1:0]   r_asm;
  logic [AW-1:0]   r_asm_a;
  logic            r_err;

  logic             w_rise;
  logic             w_start;
  logic             w_flush_wr;
  logic             w_try;
  logic             w_oor;
  logic             w_acc;
  logic             w_mism;
  logic             w_full;
  logic [c_LBW-1:0] w_lane;
  logic [AW-1:0]    w_waddr;
  logic [c_NB-1:0]  w_onehot;
  logic [c_NB-1:0]  w_mask_new;
  logic [DW-1:0]    w_asm_new;
  logic [DW-1:0]    w_fill_d;

  // r_active_d resets high so a level already present at reset release is not an edge
  assign w_rise = dl_active & ~r_active_d;

  generate
    if (c_LB == 0) begin : g_lane_none
      assign w_lane = '0;
    end else begin : g_lane_sel
      assign w_lane = dl_addr[c_LBW-1:0];
    end
  endgenerate

  assign w_waddr    = dl_addr[AW+c_LB-1:c_LB];
  assign w_try      = (r_state == S_LOAD) & dl_wr;
  assign w_oor      = |(dl_addr >> (AW + c_LB));
  assign w_acc      = w_try & ~mem_we & ~w_oor;
  assign w_mism     = w_acc & (|r_mask) & (w_waddr != r_asm_a);
  assign w_onehot   = c_NB'(1) << w_lane;
  assign w_mask_new = (w_mism ? '0 : r_mask) | w_onehot;
  assign w_full     = w_acc & (&w_mask_new);

  for (genvar k = 0; k < c_NB; k++) begin : g_lane
    assign w_asm_new[8*k +: 8] = (w_lane == c_LBW'(k)) ? dl_data : r_asm[8*k +: 8];
    assign w_fill_d[8*k +: 8]  = r_mask[k] ? r_asm[8*k +: 8] : FILL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_flush_wr = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_rise) begin
          w_state_nx = S_LOAD;
          w_start    = 1'b1;
        end
      end
      S_LOAD: begin
        if (!dl_active) begin
          w_state_nx = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (|r_mask) begin
          w_flush_wr = ~mem_we;
        end else if (!mem_we || mem_rdy) begin
          w_state_nx = S_DONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_active_d <= 1'b1;
      r_mask     <= '0;
      r_asm      <= '0;
      r_asm_a    <= '0;
      r_err      <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_d      <= '0;
    end else begin
      r_active_d <= dl_active;

      if (mem_we && mem_rdy) begin
        mem_we <= 1'b0;
      end
      if (w_full) begin
        mem_we <= 1'b1;
        mem_a  <= w_waddr;
        mem_d  <= w_asm_new;
      end else if (w_flush_wr) begin
        mem_we <= 1'b1;
        mem_a  <= r_asm_a;
        mem_d  <= w_fill_d;
      end

      if (w_start || w_full || w_flush_wr) begin
        r_mask <= '0;
      end else if (w_acc) begin
        r_mask <= w_mask_new;
      end

      if (w_acc) begin
        r_asm   <= w_asm_new;
        r_asm_a <= w_waddr;
      end

      // blocked strobe, out-of-range byte, or abandoned partial word
      if (w_start) begin
        r_err <= 1'b0;
      end else if ((w_try && (mem_we || w_oor)) || w_mism) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef ROM_LOADER_CSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= 16'h0000;
    end else if (w_start) begin
      r_csum <= 16'h0000;
    end else if (w_acc) begin
      r_csum <= r_csum + 16'(dl_data);
    end
  end

  assign csum = r_csum;
`else
  assign csum = 16'h0000;
`endif

  assign dl_wait = mem_we;
  assign busy    = (r_state == S_LOAD) | (r_state == S_FLUSH);
  assign done    = (r_state == S_DONE);
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ============================================================================
// Module   : tb_rom_loader
// Purpose  : Scoreboard bench for rom_loader (DW=16, AW=4, FILL=8'hFF).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_loader;

  localparam int         DW   = 16;
  localparam int         AW   = 4;
  localparam int         NB   = DW / 8;
  localparam int         CAP  = NB * (1 << AW);
  localparam logic [7:0] FILL = 8'hFF;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          dl_active = 1'b0;
  logic          dl_wr     = 1'b0;
  logic [24:0]   dl_addr   = '0;
  logic [7:0]    dl_data   = '0;
  logic          mem_rdy   = 1'b1;
  logic          dl_wait;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   csum;

  rom_loader #(.DW(DW), .AW(AW), .FILL(FILL)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .dl_active(dl_active),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .dl_wait  (dl_wait),
    .mem_we   (mem_we),
    .mem_rdy  (mem_rdy),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .csum     (csum)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  int  hold_q[$];
  int  stall_left = 0;
  bit  rand_rdy = 1'b0;

  // reference model of the current load
  logic [7:0]  m_byte[NB];
  bit          m_lane[NB];
  int          m_word;
  bit          m_err;
  logic [15:0] m_csum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  function automatic bit m_any();
    bit any = 1'b0;
    for (int k = 0; k < NB; k++) any |= m_lane[k];
    return any;
  endfunction

  function automatic bit m_all();
    bit all = 1'b1;
    for (int k = 0; k < NB; k++) all &= m_lane[k];
    return all;
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < NB; k++) m_lane[k] = 1'b0;
  endfunction

  function automatic void m_push_word();
    wr_t w;
    w.a = AW'(m_word);
    for (int k = 0; k < NB; k++) w.d[8*k +: 8] = m_lane[k] ? m_byte[k] : FILL;
    exp_q.push_back(w);
    m_clear();
  endfunction

  function automatic void m_byte_in(input int addr, input logic [7:0] d);
    int word;
    int lane;
    if (addr >= CAP) begin
      m_err = 1'b1;
      return;
    end
    word = addr / NB;
    lane = addr % NB;
    if (m_any() && word != m_word) begin
      m_err = 1'b1;
      m_clear();
    end
    m_word       = word;
    m_lane[lane] = 1'b1;
    m_byte[lane] = d;
    m_csum       = m_csum + 16'(d);
    if (m_all()) m_push_word();
  endfunction

  function automatic logic [15:0] exp_csum();
`ifdef ROM_LOADER_CSUM_EN
    return m_csum;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input int addr, input logic [7:0] d);
    int n = 0;
    while (dl_wait) begin
      dl_wr = 1'b0;
      cyc(1);
      n++;
      if (n > 50) begin
        timeout("dl_wait_low");
        return;
      end
    end
    dl_wr   = 1'b1;
    dl_addr = 25'(addr);
    dl_data = d;
    cyc(1);
    dl_wr = 1'b0;
    m_byte_in(addr, d);
    cyc($urandom_range(0, 1));
  endtask

  // strobe deliberately while the loader is stalled on the RAM
  task automatic send_blocked();
    int n = 0;
    while (!dl_wait) begin
      cyc(1);
      n++;
      if (n > 50) begin
        timeout("dl_wait_high");
        return;
      end
    end
    dl_wr   = 1'b1;
    dl_addr = 25'd0;
    dl_data = 8'h5A;
    cyc(1);
    dl_wr = 1'b0;
    m_err = 1'b1;
  endtask

  task automatic start_load();
    dl_active = 1'b0;
    cyc(1);
    dl_active = 1'b1;
    cyc(1);
    m_err  = 1'b0;
    m_csum = 16'h0000;
    m_clear();
    chk("load_busy", busy, 1);
    chk("load_err_clr", err, 0);
    chk("load_csum_clr", csum, 0);
  endtask

  task automatic end_load();
    int n = 0;
    dl_active = 1'b0;
    if (m_any()) m_push_word();
    while (!done && n < 100) begin
      cyc(1);
      n++;
    end
    if (!done) timeout("done");
    chk("done", done, 1);
    chk("busy_off", busy, 0);
    chk("err", err, m_err);
    chk("csum", csum, exp_csum());
    chk("writes_pending", exp_q.size(), 0);
  endtask

  // RAM ready: optional forced stall on the next write, else random or always-ready
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mem_we && stall_left > 0) begin
        mem_rdy = 1'b0;
        stall_left--;
      end else begin
        mem_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // monitor: pops the scoreboard on each completed RAM write
  initial begin
    int            hold = 0;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;
    wr_t           w;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hold = 0;
      end else begin
        chk("dl_wait_eq_we", dl_wait, mem_we);
        if (mem_we) begin
          if (hold == 0) begin
            cur_a = mem_a;
            cur_d = mem_d;
          end else begin
            chk("mem_stable", {mem_a, mem_d}, {cur_a, cur_d});
          end
          hold++;
          if (mem_rdy) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write a=%0h d=%0h", mem_a, mem_d);
            end else begin
              w = exp_q.pop_front();
              chk("wr_addr", mem_a, w.a);
              chk("wr_data", mem_d, w.d);
            end
            hold_q.push_back(hold);
            hold = 0;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int addr;
    int r;
    int nbytes;

    // reset with dl_active low
    reset_n = 1'b0;
    cyc(3);
    chk("rst_ctl", {dl_wait, mem_we, busy, done, err}, 0);
    chk("rst_mem", {mem_a, mem_d}, 0);
    chk("rst_csum", csum, 0);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_ctl", {dl_wait, mem_we, busy, done, err}, 0);

    // dl_active already high at reset release must not start a load
    reset_n   = 1'b0;
    dl_active = 1'b1;
    cyc(1);
    reset_n = 1'b1;
    cyc(4);
    chk("no_start_busy", busy, 0);

    // basic four-byte image
    start_load();
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    send_byte(2, 8'h33);
    send_byte(3, 8'h44);
    end_load();

    // first write stalled three clocks
    hold_q.delete();
    stall_left = 3;
    start_load();
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    send_byte(2, 8'h33);
    send_byte(3, 8'h44);
    end_load();
    chk("n_writes", hold_q.size(), 2);
    chk("first_hold", (hold_q.size() > 0) ? hold_q[0] : -1, 4);

    // odd length image, final word padded with FILL
    start_load();
    send_byte(0, 8'hAA);
    send_byte(1, 8'hBB);
    send_byte(2, 8'hCC);
    end_load();

    // blocked strobe and out-of-range byte
    stall_left = 3;
    start_load();
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    send_blocked();
    send_byte(32, 8'h77);
    end_load();
    cyc(5);
    chk("err_sticky", err, 1);
    chk("done_hold", done, 1);

    // randomized loads against the model
    rand_rdy = 1'b1;
    for (int t = 0; t < 10; t++) begin
      start_load();
      cur    = $urandom_range(0, CAP - 1);
      nbytes = $urandom_range(1, 14);
      for (int b = 0; b < nbytes; b++) begin
        r = $urandom_range(0, 15);
        if (r == 0)      addr = CAP + $urandom_range(0, 1000);
        else if (r == 1) addr = $urandom_range(0, CAP - 1);
        else begin
          addr = cur;
          cur  = (cur + 1) % CAP;
        end
        send_byte(addr, 8'($urandom));
      end
      end_load();
    end
    rand_rdy = 1'b0;

    // asynchronous reset in the middle of a load
    start_load();
    send_byte(4, 8'h12);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {busy, mem_we, err, done}, 0);
    cyc(1);
    exp_q.delete();
    m_clear();
    reset_n = 1'b1;
    cyc(2);
    chk("post_rst_idle", busy, 0);
    dl_active = 1'b0;
    cyc(3);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
